// File: rtl/bus_ctrl85_pkg.sv
// Shared definitions for the 8085-style bus controller: T-state and
// machine-cycle codes, status pin encoding and the registered pin bundle.
package pkg85;

   localparam logic [3:0] ST_RESET = 4'd0;
   localparam logic [3:0] ST_T1    = 4'd1;
   localparam logic [3:0] ST_T2    = 4'd2;
   localparam logic [3:0] ST_T3    = 4'd3;
   localparam logic [3:0] ST_T4    = 4'd4;
   localparam logic [3:0] ST_T5    = 4'd5;
   localparam logic [3:0] ST_T6    = 4'd6;
   localparam logic [3:0] ST_HOLD  = 4'd7;
   localparam logic [3:0] ST_HALT  = 4'd9;
   localparam logic [3:0] ST_WAIT  = 4'd10;

   localparam logic [2:0] MC_OF   = 3'd0;
   localparam logic [2:0] MC_MR   = 3'd1;
   localparam logic [2:0] MC_MW   = 3'd2;
   localparam logic [2:0] MC_IOR  = 3'd3;
   localparam logic [2:0] MC_IOW  = 3'd4;
   localparam logic [2:0] MC_INTA = 3'd5;
   localparam logic [2:0] MC_BI   = 3'd6;
   localparam logic [2:0] MC_HALT = 3'd7;

   typedef struct packed {
      logic       ale;
      logic       rd_n;
      logic       wr_n;
      logic       inta_n;
      logic       ad_oe;
      logic       bus_oe;
      logic [7:0] ad_out;
      logic [7:0] a_hi;
      logic [2:0] status;   // {io_m, s1, s0}
      logic       hlda;
   } pins_t;

   localparam pins_t PINS_IDLE = '{
      ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1, inta_n: 1'b1,
      ad_oe: 1'b0, bus_oe: 1'b0, ad_out: 8'h00, a_hi: 8'h00,
      status: 3'b000, hlda: 1'b0
   };

   function automatic logic [2:0] status_enc(input logic [2:0] mc);
      case (mc)
         MC_OF:   status_enc = 3'b011;
         MC_MR:   status_enc = 3'b010;
         MC_MW:   status_enc = 3'b001;
         MC_IOR:  status_enc = 3'b110;
         MC_IOW:  status_enc = 3'b101;
         MC_INTA: status_enc = 3'b111;
         MC_BI:   status_enc = 3'b010;
         default: status_enc = 3'b000;
      endcase
   endfunction

   function automatic logic is_read(input logic [2:0] mc);
      return (mc == MC_OF) || (mc == MC_MR) || (mc == MC_IOR);
   endfunction

   function automatic logic is_write(input logic [2:0] mc);
      return (mc == MC_MW) || (mc == MC_IOW);
   endfunction

endpackage

// File: rtl/bus_ctrl85_sync_ff.sv
// Shift-register synchroniser for an asynchronous level input.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/bus_ctrl85.sv
// Pin-level bus controller: turns the sampled T-state and cycle type into
// registered bus pins, captures read data and synchronises READY/HOLD.
module bus_ctrl85
   import pkg85::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  state,
   input  logic [2:0]  mctype,
   input  logic [15:0] addr,
   input  logic [7:0]  wrdata,
   input  logic [7:0]  ad_in,
   input  logic        ready,
   input  logic        hold,
   output logic        ready_ok,
   output logic        hold_req,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   output logic [7:0]  a_hi,
   output logic        bus_oe,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   output logic        inta_n,
   output logic        io_m,
   output logic        s1,
   output logic        s0,
   output logic        hlda,
   output logic [7:0]  rddata,
   output logic        data_valid
);

   pins_t      pins_q, pins_d;
   logic [7:0] rddata_d;
   logic       dv_d;

   always_comb begin
      // NOTE: every field gets a value before the case, so no path can infer a latch.
      pins_d      = pins_q;
      pins_d.ale  = 1'b0;
      pins_d.hlda = 1'b0;
      rddata_d    = rddata;
      dv_d        = 1'b0;

      case (state)
         ST_RESET: pins_d = PINS_IDLE;
         ST_T1: begin
            pins_d.ale    = 1'b1;
            pins_d.ad_out = addr[7:0];
            pins_d.ad_oe  = 1'b1;
            pins_d.a_hi   = addr[15:8];
            pins_d.bus_oe = 1'b1;
            pins_d.rd_n   = 1'b1;
            pins_d.wr_n   = 1'b1;
            pins_d.inta_n = 1'b1;
            pins_d.status = status_enc(mctype);
         end
         ST_T2, ST_WAIT: begin
            pins_d.bus_oe = 1'b1;
            pins_d.ad_oe  = 1'b0;
            pins_d.rd_n   = 1'b1;
            pins_d.wr_n   = 1'b1;
            pins_d.inta_n = 1'b1;
            if (is_read(mctype)) begin
               pins_d.rd_n = 1'b0;
            end else if (mctype == MC_INTA) begin
               pins_d.inta_n = 1'b0;
            end else if (is_write(mctype)) begin
               pins_d.ad_out = wrdata;
               pins_d.ad_oe  = 1'b1;
               pins_d.wr_n   = 1'b0;
            end
         end
         ST_T3: begin
            // Strobes keep their T2 level so that T3 closes the access.
            pins_d.bus_oe = 1'b1;
            if (is_read(mctype) || mctype == MC_INTA) begin
               rddata_d = ad_in;
               dv_d     = 1'b1;
            end
         end
         ST_T4, ST_T5, ST_T6: begin
            pins_d.bus_oe = 1'b1;
            pins_d.ad_oe  = 1'b0;
            pins_d.rd_n   = 1'b1;
            pins_d.wr_n   = 1'b1;
            pins_d.inta_n = 1'b1;
         end
         ST_HOLD: begin
            pins_d.bus_oe = 1'b0;
            pins_d.ad_oe  = 1'b0;
            pins_d.rd_n   = 1'b1;
            pins_d.wr_n   = 1'b1;
            pins_d.inta_n = 1'b1;
            pins_d.hlda   = 1'b1;
         end
         ST_HALT: begin
            pins_d.bus_oe = 1'b0;
            pins_d.ad_oe  = 1'b0;
            pins_d.rd_n   = 1'b1;
            pins_d.wr_n   = 1'b1;
            pins_d.inta_n = 1'b1;
            pins_d.status = 3'b000;
         end
         default: begin
            pins_d   = PINS_IDLE;
            rddata_d = 8'h00;
         end
      endcase
   end

   // NOTE: reset is asynchronous so strobes and bus drivers release without a clock; <= keeps flops race-free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pins_q     <= PINS_IDLE;
         rddata     <= 8'h00;
         data_valid <= 1'b0;
      end else begin
         pins_q     <= pins_d;
         rddata     <= rddata_d;
         data_valid <= dv_d;
      end
   end

   assign ale            = pins_q.ale;
   assign rd_n           = pins_q.rd_n;
   assign wr_n           = pins_q.wr_n;
   assign inta_n         = pins_q.inta_n;
   assign ad_oe          = pins_q.ad_oe;
   assign bus_oe         = pins_q.bus_oe;
   assign ad_out         = pins_q.ad_out;
   assign a_hi           = pins_q.a_hi;
   assign {io_m, s1, s0} = pins_q.status;
   assign hlda           = pins_q.hlda;

   sync_ff #(.STAGES(SYNC_STAGES)) u_ready_sync (
      .clock(clock), .reset(reset), .d(ready), .q(ready_ok)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_hold_sync (
      .clock(clock), .reset(reset), .d(hold), .q(hold_req)
   );

endmodule

// File: tb/tb_bus_ctrl85.sv
// Self-checking bench for bus_ctrl85: directed scenarios plus randomized
// machine cycles checked against a transaction-level expectation model.
module tb_bus_ctrl85;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  state = 4'd0;
   logic [2:0]  mctype = 3'd0;
   logic [15:0] addr = 16'h0;
   logic [7:0]  wrdata = 8'h0;
   logic [7:0]  ad_in = 8'h0;
   logic        ready = 1'b0;
   logic        hold = 1'b0;

   logic        ready_ok, hold_req, ad_oe, bus_oe, ale, rd_n, wr_n, inta_n;
   logic        io_m, s1, s0, hlda, data_valid;
   logic [7:0]  ad_out, a_hi, rddata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] model_rd = 8'h00;

   // Status pin table {io_m,s1,s0} indexed by machine-cycle type.
   logic [2:0] status_tab [8] = '{3'b011, 3'b010, 3'b001, 3'b110,
                                  3'b101, 3'b111, 3'b010, 3'b000};

   localparam logic [36:0] RST_PINS = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                       8'h00, 8'h00, 3'b000, 1'b0, 8'h00,
                                       1'b0, 1'b0, 1'b0};

   wire [36:0] pins = {ale, rd_n, wr_n, inta_n, ad_oe, bus_oe, ad_out, a_hi,
                       io_m, s1, s0, hlda, rddata, data_valid, ready_ok, hold_req};

   bus_ctrl85 #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .state(state), .mctype(mctype),
      .addr(addr), .wrdata(wrdata), .ad_in(ad_in), .ready(ready), .hold(hold),
      .ready_ok(ready_ok), .hold_req(hold_req), .ad_out(ad_out), .ad_oe(ad_oe),
      .a_hi(a_hi), .bus_oe(bus_oe), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
      .inta_n(inta_n), .io_m(io_m), .s1(s1), .s0(s0), .hlda(hlda),
      .rddata(rddata), .data_valid(data_valid)
   );

   always #5 clock = ~clock;

   task automatic step(input logic [3:0] s);
      state = s;
      @(posedge clock);
      #1;
   endtask

   // Drives T1, [T2, WAIT*n, T3], T4 and checks the whole cycle's pin activity.
   task automatic run_cycle(input logic [2:0] mc, input logic [15:0] a,
                            input logic [7:0] wd, input logic [7:0] din,
                            input int waits, input bit skip, input string tag);
      logic [3:0] seq[$];
      int   rd_lo = 0, wr_lo = 0, ia_lo = 0, ale_hi = 0, dv_hi = 0;
      int   exp_lo, exp_dv;
      bit   rdlike, wrlike, ialike;
      logic [2:0] exp_st;
      exp_st = status_tab[mc];
      rdlike = (mc == 3'd0) || (mc == 3'd1) || (mc == 3'd3);
      wrlike = (mc == 3'd2) || (mc == 3'd4);
      ialike = (mc == 3'd5);
      exp_lo = skip ? 0 : 2 + waits;
      exp_dv = ((rdlike || ialike) && !skip) ? 1 : 0;

      seq.push_back(4'd1);
      if (!skip) begin
         seq.push_back(4'd2);
         for (int w = 0; w < waits; w++) seq.push_back(4'd10);
         seq.push_back(4'd3);
      end
      seq.push_back(4'd4);

      mctype = mc; addr = a; wrdata = wd; ad_in = din;
      foreach (seq[i]) begin
         step(seq[i]);
         if (ale)        ale_hi++;
         if (!rd_n)      rd_lo++;
         if (!wr_n)      wr_lo++;
         if (!inta_n)    ia_lo++;
         if (data_valid) dv_hi++;
         if (seq[i] == 4'd1) begin
            n_cmp++;
            if ({ad_oe, bus_oe, ad_out, a_hi, io_m, s1, s0} !== {2'b11, a[7:0], a[15:8], exp_st}) begin
               n_bad++;
               $display("FAIL %s t1_pins: got oe=%b bus_oe=%b ad=%h ahi=%h st=%b want 1 1 %h %h %b",
                        tag, ad_oe, bus_oe, ad_out, a_hi, {io_m, s1, s0}, a[7:0], a[15:8], exp_st);
            end
         end
         if (!wr_n) begin
            n_cmp++;
            if ({ad_oe, ad_out} !== {1'b1, wd}) begin
               n_bad++;
               $display("FAIL %s write_data: got oe=%b ad=%h want 1 %h", tag, ad_oe, ad_out, wd);
            end
         end
      end
      if (exp_dv == 1) model_rd = din;

      n_cmp++;
      if (ale_hi !== 1) begin
         n_bad++; $display("FAIL %s ale_clocks: got %0d want 1", tag, ale_hi);
      end
      n_cmp++;
      if (rd_lo !== (rdlike ? exp_lo : 0)) begin
         n_bad++; $display("FAIL %s rd_n_low: got %0d want %0d", tag, rd_lo, rdlike ? exp_lo : 0);
      end
      n_cmp++;
      if (wr_lo !== (wrlike ? exp_lo : 0)) begin
         n_bad++; $display("FAIL %s wr_n_low: got %0d want %0d", tag, wr_lo, wrlike ? exp_lo : 0);
      end
      n_cmp++;
      if (ia_lo !== (ialike ? exp_lo : 0)) begin
         n_bad++; $display("FAIL %s inta_n_low: got %0d want %0d", tag, ia_lo, ialike ? exp_lo : 0);
      end
      n_cmp++;
      if (dv_hi !== exp_dv) begin
         n_bad++; $display("FAIL %s data_valid_clocks: got %0d want %0d", tag, dv_hi, exp_dv);
      end
      n_cmp++;
      if ({rddata, io_m, s1, s0, ad_oe} !== {model_rd, exp_st, 1'b0}) begin
         n_bad++;
         $display("FAIL %s end_state: got rd=%h st=%b oe=%b want %h %b 0",
                  tag, rddata, {io_m, s1, s0}, ad_oe, model_rd, exp_st);
      end
   endtask

   task automatic test_reset;
      #3;
      state = 4'd3; mctype = 3'd1; reset = 1'b1;
      #1;
      n_cmp++;
      if (pins !== RST_PINS) begin
         n_bad++; $display("FAIL reset_async: got %h want %h", pins, RST_PINS);
      end
      repeat (2) @(posedge clock);
      state = 4'd0;
      @(negedge clock);
      reset = 1'b0;
      repeat (3) step(4'd0);
      n_cmp++;
      if (pins !== RST_PINS) begin
         n_bad++; $display("FAIL reset_release: got %h want %h", pins, RST_PINS);
      end
      model_rd = 8'h00;
   endtask

   task automatic test_of;
      run_cycle(3'd0, 16'h1234, 8'h00, 8'h3E, 0, 1'b0, "of");
   endtask

   task automatic test_mw_wait;
      run_cycle(3'd2, 16'h2000, 8'hA5, 8'($urandom), 2, 1'b0, "mw_wait");
   endtask

   task automatic test_inta_bi;
      run_cycle(3'd5, 16'h0038, 8'h00, 8'hFF, 0, 1'b0, "inta");
      run_cycle(3'd6, 16'h4321, 8'h00, 8'h77, 0, 1'b0, "bi");
   endtask

   task automatic test_reset_state_holds;
      step(4'd0);
      n_cmp++;
      if ({ale, rd_n, wr_n, inta_n, ad_oe, bus_oe, ad_out, a_hi, io_m, s1, s0, hlda, data_valid, rddata}
          !== {4'b0111, 2'b00, 16'h0000, 3'b000, 1'b0, 1'b0, model_rd}) begin
         n_bad++;
         $display("FAIL reset_state: got %b rd=%h want idle pins rd=%h",
                  {ale, rd_n, wr_n, inta_n, ad_oe, bus_oe, io_m, s1, s0, hlda, data_valid}, rddata, model_rd);
      end
   endtask

   task automatic test_sync_hold;
      ready = 1'b1; hold = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if ({ready_ok, hold_req} !== 2'b00) begin
         n_bad++; $display("FAIL sync_edge1: got %b want 00", {ready_ok, hold_req});
      end
      @(posedge clock); #1;
      n_cmp++;
      if ({ready_ok, hold_req} !== 2'b11) begin
         n_bad++; $display("FAIL sync_edge2: got %b want 11", {ready_ok, hold_req});
      end
      step(4'd7);
      n_cmp++;
      if ({hlda, bus_oe, ad_oe} !== 3'b100) begin
         n_bad++; $display("FAIL hold_enter: got %b want 100", {hlda, bus_oe, ad_oe});
      end
      mctype = 3'd1; addr = 16'h0100;
      step(4'd1);
      n_cmp++;
      if ({hlda, bus_oe} !== 2'b01) begin
         n_bad++; $display("FAIL hold_leave: got %b want 01", {hlda, bus_oe});
      end
      step(4'd4);
      ready = 1'b0; hold = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if ({ready_ok, hold_req} !== 2'b00) begin
         n_bad++; $display("FAIL sync_fall: got %b want 00", {ready_ok, hold_req});
      end
   endtask

   task automatic test_halt;
      mctype = 3'd7;
      step(4'd9);
      n_cmp++;
      if ({bus_oe, ad_oe, io_m, s1, s0, rd_n, wr_n, inta_n, hlda} !== 9'b00_000_111_0) begin
         n_bad++;
         $display("FAIL halt: got %b want 000001110",
                  {bus_oe, ad_oe, io_m, s1, s0, rd_n, wr_n, inta_n, hlda});
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 24; k++) begin
         run_cycle(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), "rand");
      end
   endtask

   task automatic test_reset_mid;
      run_cycle(3'd1, 16'h5555, 8'h00, 8'h5A, 0, 1'b0, "mr_pre");
      mctype = 3'd3; addr = 16'h00F0;
      step(4'd1);
      step(4'd2);
      n_cmp++;
      if (rd_n !== 1'b0) begin
         n_bad++; $display("FAIL ior_t2_rd: got %b want 0", rd_n);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({rd_n, ad_oe, bus_oe, rddata} !== {3'b100, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_mid: got rd_n=%b oe=%b bus_oe=%b rd=%h want 1 0 0 00",
                  rd_n, ad_oe, bus_oe, rddata);
      end
      model_rd = 8'h00;
      state = 4'd12;
      @(negedge clock);
      reset = 1'b0;
      repeat (2) step(4'd12);
      n_cmp++;
      if (pins !== RST_PINS) begin
         n_bad++; $display("FAIL undefined_state: got %h want %h", pins, RST_PINS);
      end
   endtask

   initial begin
      test_reset();
      test_of();
      test_mw_wait();
      test_inta_bi();
      test_reset_state_holds();
      test_sync_hold();
      test_halt();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_ctrl85.md
Name: bus_ctrl85

Overview:
Pin-level bus controller for the 8085-style core. It sits directly downstream of the T-state machine and consumes its encoded T-state and machine-cycle type. It drives the multiplexed AD bus, the high address byte, ALE, RD_n, WR_n, INTA_n, IO/M, S1/S0 and HLDA. It captures read data and returns synchronised READY/HOLD indications to the state machine.

Parameters:
SYNC_STAGES, 2, flop depth of the READY and HOLD input synchronisers (minimum 2)

Ports:
clock  in  1  system clock, all flops rising-edge
reset  in  1  asynchronous, active-high reset
state  in  4  encoded T-state: 0 RESET, 1-6 T1-T6, 7 HOLD, 9 HALT, 10 WAIT; 8 and 11-15 are undefined
mctype  in  3  machine-cycle type: 0 OF, 1 MR, 2 MW, 3 IOR, 4 IOW, 5 INTA, 6 BI, 7 HALT
addr  in  16  cycle address, valid while state==T1
wrdata  in  8  write data, valid from T2 through end of cycle
ad_in  in  8  AD bus input (pad side)
ready  in  1  external READY, asynchronous
hold  in  1  external HOLD, asynchronous
ready_ok  out  1  synchronised READY to state machine
hold_req  out  1  synchronised HOLD to state machine
ad_out  out  8  AD bus output value
ad_oe  out  1  AD bus output enable
a_hi  out  8  A15-A8
bus_oe  out  1  enable for a_hi, rd_n, wr_n, inta_n, io_m
ale  out  1  address latch enable
rd_n, wr_n, inta_n  out  1 each  active-low strobes
io_m, s1, s0  out  1 each  cycle status pins
hlda  out  1  hold acknowledge
rddata  out  8  captured read data
data_valid  out  1  one-cycle pulse when rddata updates

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Every pin output is registered. Each pin reflects the `state` value sampled at the previous rising edge, i.e. one-clock lag. The state machine owns this lag.
- Reset values (also used for undefined state codes 8, 11-15): ale=0; rd_n=wr_n=inta_n=1; ad_oe=0; bus_oe=0; ad_out=0; a_hi=0; io_m=0; s1=0; s0=0; hlda=0; rddata=0; data_valid=0; synchroniser flops=0.
- Status pins {io_m,s1,s0} are loaded from mctype at T1 and held until the next T1. Encoding:
  - OF 011, MR 010, MW 001, IOR 110, IOW 101, INTA 111, BI 010, HALT 000.
- T1: ale=1; ad_out=addr[7:0], ad_oe=1; a_hi=addr[15:8], bus_oe=1; all strobes inactive.
- T2 and WAIT:
  - ale=0 in all cases.
  - Read types (OF, MR, IOR): ad_oe=0, rd_n=0.
  - INTA: ad_oe=0, inta_n=0, rd_n stays 1.
  - Write types (MW, IOW): ad_out=wrdata, ad_oe=1, wr_n=0.
  - BI: no strobe, ad_oe=0.
- T3: strobes keep their T2 levels. For read types and INTA, ad_in is registered into rddata on this edge and data_valid=1 for exactly one clock. BI, MW and IOW never pulse data_valid.
- T4-T6: all strobes inactive, ad_oe=0, a_hi and status held, bus_oe=1.
- Strobe duration: a strobe is low for (2 + number of WAIT states) clocks and goes inactive on the clock after T3 is sampled.
- HOLD (7): ad_oe=0, bus_oe=0, hlda=1. hlda drops on the clock after state leaves 7.
- HALT (9): ad_oe=0, bus_oe=0, status 000, strobes inactive, hlda=0.
- RESET (0): same outputs as the reset values, but rddata is held.
- ready_ok and hold_req: ready and hold each pass through SYNC_STAGES flops, so latency is exactly SYNC_STAGES clocks.
- Asynchronous reset mid-cycle: strobes go inactive and bus drivers release immediately, with no dependency on clock.
- State jumps without T2 (for example T1 straight to T4) generate no strobe. Consecutive T1s reload address and status each time.

Decomposition:
- Package pkg85: state code constants (ST_RESET … ST_WAIT), mctype constants, 3-bit status encoding function, and an is_read/is_write predicate.
- Sub-module sync_ff (parameter STAGES), instantiated twice, for ready and hold.

Test Plan:
1. Assert reset with state=3, mctype=1 -> all outputs at reset values with no clock edge; release -> unchanged until state≠0.
2. OF: addr=0x1234, state 1,2,3,4, ad_in=0x3E -> ale high 1 clk, ad_out=0x34, a_hi=0x12, {io_m,s1,s0}=011, rd_n low 2 clks, rddata=0x3E, data_valid pulse 1 clk.
3. MW with waits: addr=0x2000, wrdata=0xA5, state 1,2,10,10,3 -> wr_n low 4 clks, ad_out=0xA5 with ad_oe=1, status 001, data_valid never set.
4. INTA, then BI: INTA state 1,2,3 with ad_in=0xFF -> inta_n low 2 clks, rd_n stays 1, rddata=0xFF; BI state 1,2,3 -> no strobe, status 010, no data_valid.
5. Synchronisers: toggle ready 0→1 and hold 0→1 -> ready_ok and hold_req rise exactly 2 clocks later. state=7 -> hlda=1 and bus_oe=0 next clock; state=1 -> hlda=0 next clock.
6. Reset during T2 of IOR (rd_n=0) -> rd_n=1, ad_oe=0, rddata=0 immediately; undefined state 12 after reset -> reset outputs.
